// File: rtl/dense_pkg.sv
// Shared types and constants for the dense-layer sequencer: FSM states,
// fixed-point geometry and the three layer configurations of the network.
package dense_pkg;

  localparam int FIXED    = 32;
  localparam int FRAC     = 16;
  localparam int SCALE_SH = 8;
  localparam int ADDR_W   = 12;
  localparam int XADDR_W  = 7;
  localparam int NW       = 7;
  // Wide enough for 96 full-scale products plus the bias without overflow.
  localparam int ACC_W    = 2 * FIXED + NW;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    SCALE,
    OUT,
    FIN
  } state_e;

  typedef struct packed {
    logic [NW-1:0]     nb_input;
    logic [NW-1:0]     nb_neurons;
    logic [NW-1:0]     stride;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] b_base;
  } layer_cfg_t;

  // Parameter memory map: each layer's biases directly precede its weights.
  localparam layer_cfg_t DENSE1_CFG = '{nb_input: 7'd42, nb_neurons: 7'd24, stride: 7'd24,
                                        w_base: 12'd24,   b_base: 12'd0};
  localparam layer_cfg_t DENSE2_CFG = '{nb_input: 7'd24, nb_neurons: 7'd1,  stride: 7'd1,
                                        w_base: 12'd1033, b_base: 12'd1032};
  localparam layer_cfg_t DENSE3_CFG = '{nb_input: 7'd96, nb_neurons: 7'd22, stride: 7'd22,
                                        w_base: 12'd1079, b_base: 12'd1057};

endpackage

// File: rtl/dense_mac_acc.sv
// Signed multiply-accumulate datapath with bias load and 1/256 scaling.
// Build option: DENSE_SEQ_SATURATE_EN clamps the scaled result instead of wrapping.
module dense_mac_acc
  import dense_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_bias_i,
  input  logic             acc_en_i,
  input  logic [FIXED-1:0] param_data_i,
  input  logic [FIXED-1:0] x_data_i,
  output logic [FIXED-1:0] result_o
);

  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [2*FIXED-1:0] prod;

  assign prod = $signed(param_data_i) * $signed(x_data_i);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (load_bias_i) begin
      acc_d = ACC_W'($signed(param_data_i)) <<< FRAC;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef DENSE_SEQ_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(FIXED-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] scaled;
  assign scaled = acc_q >>> SCALE_SH;

  always_comb begin
    if (scaled > SAT_MAX) begin
      result_o = SAT_MAX[FIXED-1:0];
    end else if (scaled < SAT_MIN) begin
      result_o = SAT_MIN[FIXED-1:0];
    end else begin
      result_o = scaled[FIXED-1:0];
    end
  end
`else
  assign result_o = FIXED'(acc_q >>> SCALE_SH);
`endif

endmodule

// File: rtl/dense_layer_sequencer.sv
// Restartable controller that walks one dense layer neuron by neuron over a shared
// parameter memory. Build option: DENSE_SEQ_SATURATE_EN (see dense_mac_acc).
module dense_layer_sequencer
  import dense_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NW-1:0]      cfg_nb_input,
  input  logic [NW-1:0]      cfg_nb_neurons,
  input  logic [NW-1:0]      cfg_stride,
  input  logic [ADDR_W-1:0]  cfg_w_base,
  input  logic [ADDR_W-1:0]  cfg_b_base,
  output logic               param_rd,
  output logic [ADDR_W-1:0]  param_addr,
  input  logic [FIXED-1:0]   param_data,
  output logic               x_rd,
  output logic [XADDR_W-1:0] x_addr,
  input  logic [FIXED-1:0]   x_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIXED-1:0]   out_data,
  output logic [NW-1:0]      out_idx,
  output logic               busy,
  output logic               done
);

  state_e            state_q, state_d;
  layer_cfg_t        cfg_q, cfg_d;
  logic [NW-1:0]     i_q, i_d;
  logic [NW-1:0]     j_q, j_d;
  logic              out_valid_q, out_valid_d;
  logic [FIXED-1:0]  out_data_q, out_data_d;
  logic [NW-1:0]     out_idx_q, out_idx_d;
  logic              done_q;

  logic              load_bias, acc_en;
  logic [FIXED-1:0]  mac_result;
  logic [ADDR_W-1:0] w_addr;
  logic              i_last, j_last;

  // Weights are stored input-major: row j holds one weight per neuron.
  assign w_addr = cfg_q.w_base + ADDR_W'(j_q) * ADDR_W'(cfg_q.stride) + ADDR_W'(i_q);
  assign i_last = (i_q == cfg_q.nb_neurons - NW'(1));
  assign j_last = (j_q == cfg_q.nb_input - NW'(1));

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    i_d         = i_q;
    j_d         = j_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    param_rd    = 1'b0;
    param_addr  = '0;
    x_rd        = 1'b0;
    x_addr      = '0;
    load_bias   = 1'b0;
    acc_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d   = '{nb_input: cfg_nb_input, nb_neurons: cfg_nb_neurons, stride: cfg_stride,
                      w_base: cfg_w_base, b_base: cfg_b_base};
          i_d     = '0;
          state_d = (cfg_nb_neurons == '0) ? FIN : BIAS;
        end
      end
      BIAS: begin
        param_rd   = 1'b1;
        param_addr = cfg_q.b_base + ADDR_W'(i_q);
        j_d        = '0;
        state_d    = (cfg_q.nb_input == '0) ? DRAIN : MAC;
      end
      MAC: begin
        param_rd   = 1'b1;
        param_addr = w_addr;
        x_rd       = 1'b1;
        x_addr     = XADDR_W'(j_q);
        // Memory data lags the address by one cycle: bias first, then products.
        load_bias  = (j_q == '0);
        acc_en     = (j_q != '0);
        if (j_last) begin
          state_d = DRAIN;
        end else begin
          j_d = j_q + NW'(1);
        end
      end
      DRAIN: begin
        load_bias = (cfg_q.nb_input == '0);
        acc_en    = (cfg_q.nb_input != '0);
        state_d   = SCALE;
      end
      SCALE: begin
        out_valid_d = 1'b1;
        out_data_d  = mac_result;
        out_idx_d   = i_q;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (i_last) begin
            state_d = FIN;
          end else begin
            i_d     = i_q + NW'(1);
            state_d = BIAS;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      i_q         <= i_d;
      j_q         <= j_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      done_q      <= (state_q == FIN);
    end
  end

  dense_mac_acc u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_bias_i  (load_bias),
    .acc_en_i     (acc_en),
    .param_data_i (param_data),
    .x_data_i     (x_data),
    .result_o     (mac_result)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE) && (state_q != FIN);

endmodule
